input_skew_feeder: RTL and testbench



---
 rtl/input_skew_feeder_pkg.sv | 16 +
 rtl/input_skew_feeder_if.sv | 31 +++
 rtl/input_skew_feeder_skew_delay_line.sv | 43 ++++
 rtl/input_skew_feeder.sv | 81 ++++++++
 tb/tb_input_skew_feeder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/input_skew_feeder_pkg.sv
// Shared types and defaults for the systolic-array west-edge feeder.
package input_skew_feeder_pkg;

   localparam int unsigned DATA_WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } feeder_state_t;

   function automatic int unsigned drain_cnt_width(input int unsigned rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/input_skew_feeder_if.sv
// Upstream beat handshake into the feeder: one ROWS-wide activation vector per beat.
interface input_skew_feeder_if
   import input_skew_feeder_pkg::*;
#(
   parameter int unsigned ROWS       = 4,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
);

   logic                       in_valid;
   logic                       in_ready;
   logic [ROWS*DATA_WIDTH-1:0] in_data;
   logic                       in_switch;
   logic                       in_last;

   modport master (
      output in_valid,
      output in_data,
      output in_switch,
      output in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_switch,
      input  in_last,
      output in_ready
   );

endinterface

// File: rtl/input_skew_feeder_skew_delay_line.sv
// DEPTH-stage shift register carrying {data, valid, switch} for one PE row.
module input_skew_feeder_skew_delay_line #(
   parameter int unsigned DEPTH      = 1,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  in_switch,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_switch
);

   logic [DATA_WIDTH-1:0] data_q   [DEPTH];
   logic                  valid_q  [DEPTH];
   logic                  switch_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i]   <= '0;
            valid_q[i]  <= 1'b0;
            switch_q[i] <= 1'b0;
         end
      end else begin
         data_q[0]   <= in_data;
         valid_q[0]  <= in_valid;
         switch_q[0] <= in_switch;
         for (int i = 1; i < int'(DEPTH); i++) begin
            data_q[i]   <= data_q[i-1];
            valid_q[i]  <= valid_q[i-1];
            switch_q[i] <= switch_q[i-1];
         end
      end
   end

   assign out_data   = data_q[DEPTH-1];
   assign out_valid  = valid_q[DEPTH-1];
   assign out_switch = switch_q[DEPTH-1];

endmodule

// File: rtl/input_skew_feeder.sv
// West-edge feeder: skews row r of each accepted beat by r+1 cycles and drains at end of tile.
module input_skew_feeder
   import input_skew_feeder_pkg::*;
#(
   parameter int unsigned ROWS       = 4,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input_skew_feeder_if.slave         up,
   output logic [ROWS*DATA_WIDTH-1:0] row_input,
   output logic [ROWS-1:0]            row_valid,
   output logic [ROWS-1:0]            row_switch,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned CNT_W = drain_cnt_width(ROWS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS - 1);

   feeder_state_t              state_q;
   logic [CNT_W-1:0]           cnt_q;
   logic                       accept;
   logic [ROWS*DATA_WIDTH-1:0] beat_data;
   logic                       beat_switch;

   // Ready only depends on registered state; reset gates it so nothing lands during reset.
   assign up.in_ready = (state_q != DRAIN) && !rst;
   assign accept      = up.in_valid && up.in_ready;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DRAIN) && (cnt_q == CNT_LAST);

   // Non-accepted cycles inject a zero bubble so stale inputs never reach the array.
   assign beat_data   = accept ? up.in_data : '0;
   assign beat_switch = accept && up.in_switch;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE, STREAM: begin
               cnt_q <= '0;
               if (accept) begin
                  state_q <= up.in_last ? DRAIN : STREAM;
               end
            end
            DRAIN: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
      input_skew_feeder_skew_delay_line #(
         .DEPTH      (r + 1),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_delay (
         .clk        (clk),
         .rst        (rst),
         .in_data    (beat_data[r*DATA_WIDTH +: DATA_WIDTH]),
         .in_valid   (accept),
         .in_switch  (beat_switch),
         .out_data   (row_input[r*DATA_WIDTH +: DATA_WIDTH]),
         .out_valid  (row_valid[r]),
         .out_switch (row_switch[r])
      );
   end

endmodule

// File: tb/tb_input_skew_feeder.sv
// Directed bench for input_skew_feeder: a ROWS=4 instance and a ROWS=1 instance.
module tb_input_skew_feeder;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   input_skew_feeder_if #(.ROWS(4), .DATA_WIDTH(16)) bus4 ();
   input_skew_feeder_if #(.ROWS(1), .DATA_WIDTH(16)) bus1 ();

   logic [63:0] row_input4;
   logic [3:0]  row_valid4;
   logic [3:0]  row_switch4;
   logic        busy4;
   logic        done4;
   logic [15:0] row_input1;
   logic [0:0]  row_valid1;
   logic [0:0]  row_switch1;
   logic        busy1;
   logic        done1;

   input_skew_feeder #(.ROWS(4), .DATA_WIDTH(16)) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .up         (bus4.slave),
      .row_input  (row_input4),
      .row_valid  (row_valid4),
      .row_switch (row_switch4),
      .busy       (busy4),
      .done       (done4)
   );

   input_skew_feeder #(.ROWS(1), .DATA_WIDTH(16)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .up         (bus1.slave),
      .row_input  (row_input1),
      .row_valid  (row_valid1),
      .row_switch (row_switch1),
      .busy       (busy1),
      .done       (done1)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Sample 1 time unit after the active edge; "cycle n" is the state after edge n.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive4(input logic v, input logic [63:0] d, input logic sw, input logic lst);
      bus4.in_valid  = v;
      bus4.in_data   = d;
      bus4.in_switch = sw;
      bus4.in_last   = lst;
   endtask

   task automatic drive1(input logic v, input logic [15:0] d, input logic sw, input logic lst);
      bus1.in_valid  = v;
      bus1.in_data   = d;
      bus1.in_switch = sw;
      bus1.in_last   = lst;
   endtask

   function automatic logic [63:0] vec4(input logic [15:0] r3, input logic [15:0] r2,
                                        input logic [15:0] r1, input logic [15:0] r0);
      return {r3, r2, r1, r0};
   endfunction

   logic [63:0] a, b, c, x, y, p, q;

   initial begin
      rst = 1'b1;
      drive4(1'b0, '0, 1'b0, 1'b0);
      drive1(1'b0, '0, 1'b0, 1'b0);
      tick();
      tick();
      check("rst_valid", 64'(row_valid4), 64'h0);
      check("rst_busy", 64'(busy4), 64'h0);
      check("rst_done", 64'(done4), 64'h0);
      check("rst_ready_low", 64'(bus4.in_ready), 64'h0);
      rst = 1'b0;
      #1;
      check("rst_ready_high", 64'(bus4.in_ready), 64'h1);

      // Single-beat tile: row r shows r+1 in cycle r+1, done in cycle 4.
      drive4(1'b1, vec4(16'd4, 16'd3, 16'd2, 16'd1), 1'b0, 1'b1);
      tick();
      drive4(1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b1);
      for (int cyc = 1; cyc <= 4; cyc++) begin
         check("t1_valid", 64'(row_valid4), 64'h1 << (cyc - 1));
         check("t1_data", row_input4, 64'(cyc) << (16 * (cyc - 1)));
         check("t1_switch", 64'(row_switch4), 64'h0);
         check("t1_ready", 64'(bus4.in_ready), 64'h0);
         check("t1_busy", 64'(busy4), 64'h1);
         check("t1_done", 64'(done4), 64'(cyc == 4));
         tick();
      end
      check("t1_ready_c5", 64'(bus4.in_ready), 64'h1);
      check("t1_busy_c5", 64'(busy4), 64'h0);
      check("t1_valid_c5", 64'(row_valid4), 64'h0);

      // Three consecutive beats, switch on the first only.
      a = vec4(16'hA3, 16'hA2, 16'hA1, 16'hA0);
      b = vec4(16'hB3, 16'hB2, 16'hB1, 16'hB0);
      c = vec4(16'hC3, 16'hC2, 16'hC1, 16'hC0);
      drive4(1'b1, a, 1'b1, 1'b0);
      tick();
      check("t2_c1_valid", 64'(row_valid4), 64'b0001);
      check("t2_c1_switch", 64'(row_switch4), 64'b0001);
      check("t2_c1_busy", 64'(busy4), 64'h1);
      drive4(1'b1, b, 1'b0, 1'b0);
      tick();
      check("t2_c2_valid", 64'(row_valid4), 64'b0011);
      check("t2_c2_switch", 64'(row_switch4), 64'b0010);
      drive4(1'b1, c, 1'b0, 1'b1);
      tick();
      drive4(1'b0, '0, 1'b0, 1'b0);
      check("t2_c3_row2", 64'(row_input4[47:32]), 64'hA2);
      check("t2_c3_valid", 64'(row_valid4), 64'b0111);
      check("t2_c3_switch", 64'(row_switch4), 64'b0100);
      check("t2_c3_ready", 64'(bus4.in_ready), 64'h0);
      tick();
      check("t2_c4_row2", 64'(row_input4[47:32]), 64'hB2);
      check("t2_c4_row3", 64'(row_input4[63:48]), 64'hA3);
      check("t2_c4_switch", 64'(row_switch4), 64'b1000);
      tick();
      check("t2_c5_row2", 64'(row_input4[47:32]), 64'hC2);
      check("t2_c5_valid", 64'(row_valid4), 64'b1100);
      check("t2_c5_done", 64'(done4), 64'h0);
      tick();
      check("t2_c6_row3", 64'(row_input4[63:48]), 64'hC3);
      check("t2_c6_done", 64'(done4), 64'h1);
      tick();
      check("t2_c7_ready", 64'(bus4.in_ready), 64'h1);
      check("t2_c7_done", 64'(done4), 64'h0);

      // Mid-tile bubble with junk on the idle data/switch lines.
      drive4(1'b1, a, 1'b0, 1'b0);
      tick();
      drive4(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
      tick();
      drive4(1'b1, b, 1'b0, 1'b1);
      tick();
      drive4(1'b0, '0, 1'b0, 1'b0);
      tick();
      check("t3_c4_valid3", 64'(row_valid4[3]), 64'h1);
      check("t3_c4_row3", 64'(row_input4[63:48]), 64'hA3);
      tick();
      check("t3_c5_valid3", 64'(row_valid4[3]), 64'h0);
      check("t3_c5_row3", 64'(row_input4[63:48]), 64'h0);
      check("t3_c5_switch", 64'(row_switch4), 64'h0);
      tick();
      check("t3_c6_valid3", 64'(row_valid4[3]), 64'h1);
      check("t3_c6_row3", 64'(row_input4[63:48]), 64'hB3);
      check("t3_c6_done", 64'(done4), 64'h1);
      tick();

      // in_valid held high through DRAIN: nothing accepted until cycle 5.
      x = vec4(16'h0404, 16'h0303, 16'h0202, 16'h0101);
      y = vec4(16'h7773, 16'h7772, 16'h7771, 16'h7770);
      drive4(1'b1, x, 1'b0, 1'b1);
      tick();
      for (int cyc = 1; cyc <= 4; cyc++) begin
         drive4(1'b1, vec4(16'(cyc), 16'hE0E0, 16'hE1E1, 16'(cyc)), 1'b1, 1'b0);
         check("t4_valid", 64'(row_valid4), 64'h1 << (cyc - 1));
         check("t4_switch", 64'(row_switch4), 64'h0);
         check("t4_ready", 64'(bus4.in_ready), 64'h0);
         tick();
      end
      check("t4_c5_ready", 64'(bus4.in_ready), 64'h1);
      check("t4_c5_valid", 64'(row_valid4), 64'h0);
      drive4(1'b1, y, 1'b0, 1'b1);
      tick();
      drive4(1'b0, '0, 1'b0, 1'b0);
      check("t4_c6_valid", 64'(row_valid4), 64'b0001);
      check("t4_c6_row0", 64'(row_input4[15:0]), 64'h7770);
      for (int i = 0; i < 4; i++) tick();
      check("t4_idle", 64'(busy4), 64'h0);

      // Reset asserted in cycle 2 of a stream.
      p = vec4(16'h1113, 16'h1112, 16'h1111, 16'h1110);
      q = vec4(16'h2223, 16'h2222, 16'h2221, 16'h2220);
      drive4(1'b1, p, 1'b1, 1'b0);
      tick();
      drive4(1'b1, q, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      drive4(1'b1, a, 1'b1, 1'b0);
      #1;
      check("t5_c2_ready", 64'(bus4.in_ready), 64'h0);
      tick();
      check("t5_c3_input", row_input4, 64'h0);
      check("t5_c3_valid", 64'(row_valid4), 64'h0);
      check("t5_c3_switch", 64'(row_switch4), 64'h0);
      check("t5_c3_busy", 64'(busy4), 64'h0);
      check("t5_c3_done", 64'(done4), 64'h0);
      check("t5_c3_ready", 64'(bus4.in_ready), 64'h0);
      tick();
      rst = 1'b0;
      drive4(1'b0, '0, 1'b0, 1'b0);
      #1;
      check("t5_c4_ready", 64'(bus4.in_ready), 64'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t5_no_stale", 64'(row_valid4), 64'h0);
         check("t5_busy", 64'(busy4), 64'h0);
      end

      // ROWS=1: last and switch on the same beat, one-cycle drain.
      drive1(1'b1, 16'h00C1, 1'b1, 1'b1);
      tick();
      drive1(1'b0, 16'hFFFF, 1'b0, 1'b0);
      check("r1_valid", 64'(row_valid1), 64'h1);
      check("r1_data", 64'(row_input1), 64'hC1);
      check("r1_switch", 64'(row_switch1), 64'h1);
      check("r1_done", 64'(done1), 64'h1);
      check("r1_ready_c1", 64'(bus1.in_ready), 64'h0);
      check("r1_busy_c1", 64'(busy1), 64'h1);
      tick();
      check("r1_ready_c2", 64'(bus1.in_ready), 64'h1);
      check("r1_done_c2", 64'(done1), 64'h0);
      check("r1_busy_c2", 64'(busy1), 64'h0);
      check("r1_valid_c2", 64'(row_valid1), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
